// File: rtl/efuse_macro_emu.sv
// Behavioural emulation of a 256-bit one-time-programmable eFuse macro with
// strobe-timed program pulses, fixed-latency byte reads and sticky error flags.
module efuse_macro_emu #(
    parameter int unsigned    PGM_CYC  = 4,
    parameter int unsigned    RD_LAT   = 2,
    parameter logic [255:0]   INIT_VAL = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       efuse_pgmen_i,
    input  logic       efuse_rden_i,
    input  logic       efuse_aen_i,
    input  logic [7:0] efuse_addr_i,
    input  logic       err_clr_i,
    output logic [7:0] efuse_rdata_o,
    output logic       pgm_done_o,
    output logic [1:0] err_o
);

    localparam logic [3:0] PGM_CYC_W = 4'(PGM_CYC);
    localparam logic [3:0] RD_LAT_W  = 4'(RD_LAT);

    typedef enum logic [1:0] {StIdle, StPgm, StRd} state_e;

    state_e       r_state;
    logic [3:0]   r_cnt;
    logic [7:0]   r_addr;
    logic [255:0] r_array;
    logic [7:0]   r_rdata;
    logic         r_pgm_done;
    logic [1:0]   r_err;
    logic         r_aen_prev;
    // Set once aen has been sampled low after reset, so a strobe already
    // high when reset releases is not mistaken for a rise.
    logic         r_aen_armed;

    logic         w_aen_rise;
    logic [1:0]   w_err_set;

    assign w_aen_rise = efuse_aen_i & ~r_aen_prev & r_aen_armed;

    always_comb begin
        w_err_set = 2'b00;
        case (r_state)
            StIdle: begin
                if (w_aen_rise && efuse_pgmen_i && efuse_rden_i) begin
                    w_err_set[0] = 1'b1;
                end
            end
            StPgm: begin
                if (efuse_rden_i) begin
                    w_err_set = 2'b11;
                end else if (!efuse_aen_i) begin
                    w_err_set[1] = (r_cnt < PGM_CYC_W);
                end else if (!efuse_pgmen_i) begin
                    w_err_set[1] = 1'b1;
                end
            end
            StRd: begin
                if (!efuse_rden_i) begin
                    w_err_set[1] = 1'b1;
                end
            end
            default: w_err_set = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_array     <= INIT_VAL;
            r_rdata     <= '0;
            r_pgm_done  <= 1'b0;
            r_err       <= '0;
            r_aen_prev  <= 1'b0;
            r_aen_armed <= 1'b0;
        end else begin
            r_aen_prev <= efuse_aen_i;
            if (!efuse_aen_i) begin
                r_aen_armed <= 1'b1;
            end
            r_pgm_done <= 1'b0;
            // A flag raised in the same cycle as a clear survives.
            r_err <= (err_clr_i ? 2'b00 : r_err) | w_err_set;

            case (r_state)
                StIdle: begin
                    if (w_aen_rise && efuse_pgmen_i && !efuse_rden_i) begin
                        r_addr  <= efuse_addr_i;
                        r_cnt   <= 4'd1;
                        r_state <= StPgm;
                    end else if (w_aen_rise && efuse_rden_i && !efuse_pgmen_i) begin
                        r_addr  <= efuse_addr_i;
                        r_cnt   <= 4'd1;
                        r_state <= StRd;
                    end
                end
                StPgm: begin
                    if (efuse_rden_i) begin
                        r_cnt   <= '0;
                        r_state <= StIdle;
                    end else if (!efuse_aen_i) begin
                        if (r_cnt >= PGM_CYC_W) begin
                            r_array[r_addr] <= 1'b1;
                            r_pgm_done      <= 1'b1;
                        end
                        r_cnt   <= '0;
                        r_state <= StIdle;
                    end else if (!efuse_pgmen_i) begin
                        r_cnt   <= '0;
                        r_state <= StIdle;
                    end else if (r_cnt < PGM_CYC_W) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                StRd: begin
                    if (!efuse_rden_i) begin
                        r_cnt   <= '0;
                        r_state <= StIdle;
                    end else if (r_cnt >= RD_LAT_W) begin
                        r_rdata <= r_array[{r_addr[7:3], 3'b000} +: 8];
                        r_cnt   <= '0;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign efuse_rdata_o = r_rdata;
    assign pgm_done_o    = r_pgm_done;
    assign err_o         = r_err;

endmodule
